// File: rtl/binary_code_pkg.sv
// Shared types for the 8-line binary encoder/decoder pair.
// Line count, code width, code type and encoder FSM states.
package binary_code_pkg;

   localparam int N_LINES = 8;
   localparam int CODE_W  = 3;

   typedef logic [CODE_W-1:0]  code_t;
   typedef logic [N_LINES-1:0] lines_t;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      WAIT_RELEASE
   } enc_state_t;

   // True when more than one bit is set: clearing the lowest set bit leaves a residue.
   function automatic logic multi_hot(input lines_t v);
      return (v & (v - lines_t'(1))) != '0;
   endfunction

endpackage

// File: rtl/input_synchronizer.sv
// Per-bit flop chain that brings asynchronous request lines into the clk domain.
// Asynchronous active-low clear empties every stage.
module input_synchronizer #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_chain [STAGES];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < STAGES; s++) begin
            r_chain[s] <= '0;
         end
      end else begin
         r_chain[0] <= i_d;
         for (int s = 1; s < STAGES; s++) begin
            r_chain[s] <= r_chain[s-1];
         end
      end
   end

   assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/priority_encoder8.sv
// 8-to-3 priority encoder with synchronised inputs and a held, acked event per press.
// One capture per press; the line set must fully release before the next capture.
module priority_encoder8
   import binary_code_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter bit LSB_PRIORITY = 1'b0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N_LINES-1:0] y,
   input  logic               ack,
   output logic [CODE_W-1:0]  d,
   output logic               valid,
   output logic               multi
);

   lines_t     w_y_s;
   logic       w_any;
   logic       w_many;
   code_t      w_code;

   enc_state_t r_state;
   code_t      r_d;
   logic       r_valid;
   logic       r_multi;

   function automatic code_t encode(input lines_t v, input bit lsb_first);
      code_t c;
      c = '0;
      // Last hit in scan order wins, so scan toward the preferred end.
      if (lsb_first) begin
         for (int i = N_LINES - 1; i >= 0; i--) begin
            if (v[i]) c = code_t'(i);
         end
      end else begin
         for (int i = 0; i < N_LINES; i++) begin
            if (v[i]) c = code_t'(i);
         end
      end
      return c;
   endfunction

   input_synchronizer #(
      .WIDTH  (N_LINES),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_d     (y),
      .o_q     (w_y_s)
   );

   assign w_any  = |w_y_s;
   assign w_many = multi_hot(w_y_s);
   assign w_code = encode(w_y_s, LSB_PRIORITY);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_d     <= '0;
         r_valid <= 1'b0;
         r_multi <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_d     <= w_code;
                  r_multi <= w_many;
                  r_valid <= 1'b1;
                  r_state <= HOLD;
               end
            end
            HOLD: begin
               if (ack) begin
                  r_valid <= 1'b0;
                  r_state <= WAIT_RELEASE;
               end
            end
            WAIT_RELEASE: begin
               if (!w_any) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign d     = r_d;
   assign valid = r_valid;
   assign multi = r_multi;

endmodule

// File: tb/tb_priority_encoder8.sv
// Directed bench for priority_encoder8: MSB-priority instance plus an LSB-priority twin
// driven from the same inputs.
module tb_priority_encoder8;

   logic       clk;
   logic       reset_n;
   logic [7:0] y;
   logic       ack;
   logic [2:0] d_h;
   logic       valid_h;
   logic       multi_h;
   logic [2:0] d_l;
   logic       valid_l;
   logic       multi_l;

   int checks;
   int errors;

   priority_encoder8 #(.SYNC_STAGES(2), .LSB_PRIORITY(1'b0)) dut_h (
      .clk     (clk),
      .reset_n (reset_n),
      .y       (y),
      .ack     (ack),
      .d       (d_h),
      .valid   (valid_h),
      .multi   (multi_h)
   );

   priority_encoder8 #(.SYNC_STAGES(2), .LSB_PRIORITY(1'b1)) dut_l (
      .clk     (clk),
      .reset_n (reset_n),
      .y       (y),
      .ack     (ack),
      .d       (d_l),
      .valid   (valid_l),
      .multi   (multi_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      y = 8'hFF;
      ack = 1'b0;
      reset_n = 1'b0;
      #3;
      checks++;
      if (valid_h !== 1'b0 || d_h !== 3'b000 || multi_h !== 1'b0) begin
         $display("FAIL reset_immediate: valid=%b d=%b multi=%b want 0 000 0",
                  valid_h, d_h, multi_h);
         errors++;
      end
      step(3);
      checks++;
      if (valid_h !== 1'b0 || d_h !== 3'b000) begin
         $display("FAIL reset_held: valid=%b d=%b want 0 000", valid_h, d_h);
         errors++;
      end
      reset_n = 1'b1;
      step(2);
      checks++;
      if (valid_h !== 1'b0) begin
         $display("FAIL reset_release_early: valid=%b want 0", valid_h);
         errors++;
      end
      step(1);
      checks++;
      if (valid_h !== 1'b1 || d_h !== 3'd7 || multi_h !== 1'b1
          || d_l !== 3'd0 || multi_l !== 1'b1) begin
         $display("FAIL reset_release_event: valid=%b d=%0d multi=%b lsb_d=%0d want 1 7 1 0",
                  valid_h, d_h, multi_h, d_l);
         errors++;
      end
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      y = 8'h00;
      step(4);
   endtask

   task automatic test_sweep();
      for (int i = 0; i < 8; i++) begin
         logic [7:0] v;
         v = 8'h01 << i;
         y = v;
         step(2);
         checks++;
         if (valid_h !== 1'b0) begin
            $display("FAIL sweep_early[%0d]: valid=%b want 0", i, valid_h);
            errors++;
         end
         step(1);
         checks++;
         if (valid_h !== 1'b1 || d_h !== i[2:0] || multi_h !== 1'b0
             || valid_l !== 1'b1 || d_l !== i[2:0]) begin
            $display("FAIL sweep_event[%0d]: valid=%b d=%0d multi=%b lsb_d=%0d want 1 %0d 0",
                     i, valid_h, d_h, multi_h, d_l, i);
            errors++;
         end
         ack = 1'b1;
         step(1);
         ack = 1'b0;
         checks++;
         if (valid_h !== 1'b0 || d_h !== i[2:0]) begin
            $display("FAIL sweep_ack[%0d]: valid=%b d=%0d want 0 %0d", i, valid_h, d_h, i);
            errors++;
         end
         y = 8'h00;
         step(4);
      end
   endtask

   task automatic test_multi();
      y = 8'b1010_0001;
      step(3);
      checks++;
      if (valid_h !== 1'b1 || d_h !== 3'b111 || multi_h !== 1'b1) begin
         $display("FAIL multi_msb: valid=%b d=%b multi=%b want 1 111 1",
                  valid_h, d_h, multi_h);
         errors++;
      end
      checks++;
      if (valid_l !== 1'b1 || d_l !== 3'b000 || multi_l !== 1'b1) begin
         $display("FAIL multi_lsb: valid=%b d=%b multi=%b want 1 000 1",
                  valid_l, d_l, multi_l);
         errors++;
      end
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      y = 8'h00;
      step(4);
   endtask

   task automatic test_hold();
      int bad;
      y = 8'b0001_0000;
      step(3);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (valid_h !== 1'b1 || d_h !== 3'b100) bad++;
         step(1);
      end
      checks++;
      if (bad != 0) begin
         $display("FAIL hold_frozen: %0d bad cycles, want 0", bad);
         errors++;
      end
      y = 8'b0000_0010;
      step(5);
      checks++;
      if (valid_h !== 1'b1 || d_h !== 3'b100 || multi_h !== 1'b0) begin
         $display("FAIL hold_change: valid=%b d=%b multi=%b want 1 100 0",
                  valid_h, d_h, multi_h);
         errors++;
      end
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      step(6);
      checks++;
      if (valid_h !== 1'b0 || d_h !== 3'b100) begin
         $display("FAIL hold_wait_release: valid=%b d=%b want 0 100", valid_h, d_h);
         errors++;
      end
   endtask

   task automatic test_back_to_back();
      int rises;
      logic prev;
      y = 8'h00;
      step(2);
      y = 8'b0000_0100;
      rises = 0;
      prev = valid_h;
      for (int c = 0; c < 12; c++) begin
         step(1);
         if (valid_h === 1'b1 && prev === 1'b0) rises++;
         prev = valid_h;
      end
      checks++;
      if (rises != 1 || valid_h !== 1'b1 || d_h !== 3'b010) begin
         $display("FAIL b2b_event: rises=%0d valid=%b d=%b want 1 1 010",
                  rises, valid_h, d_h);
         errors++;
      end
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      y = 8'h00;
      step(4);
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      step(2);
      checks++;
      if (valid_h !== 1'b0 || d_h !== 3'b010) begin
         $display("FAIL stray_ack: valid=%b d=%b want 0 010", valid_h, d_h);
         errors++;
      end
   endtask

   task automatic test_reset_mid();
      y = 8'b0100_0000;
      step(3);
      checks++;
      if (valid_h !== 1'b1 || d_h !== 3'b110) begin
         $display("FAIL midreset_pre: valid=%b d=%b want 1 110", valid_h, d_h);
         errors++;
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (valid_h !== 1'b0 || d_h !== 3'b000 || multi_h !== 1'b0) begin
         $display("FAIL midreset_clear: valid=%b d=%b multi=%b want 0 000 0",
                  valid_h, d_h, multi_h);
         errors++;
      end
      step(1);
      reset_n = 1'b1;
      step(2);
      checks++;
      if (valid_h !== 1'b0) begin
         $display("FAIL midreset_early: valid=%b want 0", valid_h);
         errors++;
      end
      step(1);
      checks++;
      if (valid_h !== 1'b1 || d_h !== 3'b110) begin
         $display("FAIL midreset_event: valid=%b d=%b want 1 110", valid_h, d_h);
         errors++;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset_n = 1'b1;
      y = 8'h00;
      ack = 1'b0;
      #2;
      test_reset();
      test_sweep();
      test_multi();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
